// File: rtl/instr_mem_loader.sv
// Byte-stream loader for the instruction memory: parses a count header, packs 3-byte words
// and writes them from START_ADDR upward while holding the CPU. Option: LOADER_CHECKSUM_EN.
module instr_mem_loader #(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 19,
    parameter int START_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_written
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_HDR_HI = 4'd1,
        S_HDR_LO = 4'd2,
        S_B2     = 4'd3,
        S_B1     = 4'd4,
        S_B0     = 4'd5,
        S_WRITE  = 4'd6,
        S_CSUM   = 4'd7,
        S_END    = 4'd8
    } state_t;

    // Words that fit between START_ADDR and the top of memory.
    localparam logic [16:0]       CAPACITY = 17'((1 << ADDR_W) - START_ADDR);
    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(START_ADDR);

    state_t            state_q, state_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [7:0]        b2_q, b2_d;
    logic [7:0]        b1_q, b1_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic [ADDR_W:0]   ww_q, ww_d;

    logic              xfer_s;
    logic [15:0]       hdr_n_s;
    logic [ADDR_W:0]   ww_inc_s;
    logic              last_word_s;
    logic              csum_bad_s;
    state_t            after_payload_s;

    assign in_ready = (state_q == S_HDR_HI) || (state_q == S_HDR_LO) ||
                      (state_q == S_B2)     || (state_q == S_B1)     ||
                      (state_q == S_B0)     || (state_q == S_CSUM);
    assign xfer_s      = in_valid & in_ready;
    assign hdr_n_s     = {cnt_q[15:8], in_data};
    assign ww_inc_s    = ww_q + {{ADDR_W{1'b0}}, 1'b1};
    assign last_word_s = (17'(ww_inc_s) == {1'b0, cnt_q});

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] csum_q, csum_d;

    assign after_payload_s = S_CSUM;
    assign csum_bad_s      = (in_data != csum_q);

    // Running XOR over every header and payload byte of the current load.
    always_comb begin
        csum_d = csum_q;
        if ((state_q == S_IDLE) && start) begin
            csum_d = 8'h00;
        end else if (xfer_s && (state_q != S_CSUM)) begin
            csum_d = csum_q ^ in_data;
        end else begin
            csum_d = csum_q;
        end
    end

    // Checksum accumulator register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csum_q <= 8'h00;
        end else begin
            csum_q <= csum_d;
        end
    end
`else
    assign after_payload_s = S_END;
    assign csum_bad_s      = 1'b0;
`endif

    // Next-state and output computation for the load sequencer.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        b2_d        = b2_q;
        b1_d        = b1_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        error_d     = error_q;
        ww_d        = ww_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_HDR_HI;
                    error_d = 1'b0;
                    ww_d    = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_HDR_HI: begin
                if (xfer_s) begin
                    cnt_d   = {in_data, 8'h00};
                    state_d = S_HDR_LO;
                end else begin
                    state_d = S_HDR_HI;
                end
            end
            S_HDR_LO: begin
                if (xfer_s) begin
                    cnt_d = hdr_n_s;
                    if (hdr_n_s == 16'd0) begin
                        state_d = after_payload_s;
                    end else if ({1'b0, hdr_n_s} > CAPACITY) begin
                        // Oversized image: flag it and skip payload and checksum.
                        error_d = 1'b1;
                        state_d = S_END;
                    end else begin
                        state_d = S_B2;
                    end
                end else begin
                    state_d = S_HDR_LO;
                end
            end
            S_B2: begin
                if (xfer_s) begin
                    b2_d    = in_data;
                    state_d = S_B1;
                end else begin
                    state_d = S_B2;
                end
            end
            S_B1: begin
                if (xfer_s) begin
                    b1_d    = in_data;
                    state_d = S_B0;
                end else begin
                    state_d = S_B1;
                end
            end
            S_B0: begin
                if (xfer_s) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = BASE + ww_q[ADDR_W-1:0];
                    mem_wdata_d = DATA_W'({b2_q, b1_q, in_data});
                    state_d     = S_WRITE;
                end else begin
                    state_d = S_B0;
                end
            end
            S_WRITE: begin
                ww_d = ww_inc_s;
                if (last_word_s) begin
                    state_d = after_payload_s;
                end else begin
                    state_d = S_B2;
                end
            end
            S_CSUM: begin
                if (xfer_s) begin
                    if (csum_bad_s) begin
                        error_d = 1'b1;
                    end else begin
                        error_d = error_q;
                    end
                    state_d = S_END;
                end else begin
                    state_d = S_CSUM;
                end
            end
            S_END: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Status flags follow the state being entered so they are registered.
        busy_d = (state_d != S_IDLE) && (state_d != S_END);
        done_d = (state_d == S_END);
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 16'd0;
            b2_q        <= 8'h00;
            b1_q        <= 8'h00;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            ww_q        <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            b2_q        <= b2_d;
            b1_q        <= b1_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            ww_q        <= ww_d;
        end
    end

    assign mem_we        = mem_we_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign busy          = busy_q;
    assign cpu_hold      = busy_q;
    assign done          = done_q;
    assign error         = error_q;
    assign words_written = ww_q;

endmodule
